// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, pipeline control
// inputs and the IF/ID register outputs toward decode.
interface instr_fetch_if #(
   parameter int unsigned PC_WIDTH = 16
);
   logic [PC_WIDTH-1:0] imem_addr;
   logic [15:0]         imem_instr;
   logic                stall;
   logic                flush;
   logic                branch_taken;
   logic [PC_WIDTH-1:0] branch_target;
   logic [15:0]         if_instr;
   logic [PC_WIDTH-1:0] if_pc;
   logic                if_valid;
   logic                halted;
   logic [15:0]         fetch_count;
   logic                fetch_err;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  stall,
      input  flush,
      input  branch_taken,
      input  branch_target,
      output if_instr,
      output if_pc,
      output if_valid,
      output halted,
      output fetch_count,
      output fetch_err
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output stall,
      output flush,
      output branch_taken,
      output branch_target,
      input  if_instr,
      input  if_pc,
      input  if_valid,
      input  halted,
      input  fetch_count,
      input  fetch_err
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the 16-bit Thumb-subset core: PC, IF/ID register, halt.
// FETCH_ALIGN_CHECK_EN traps misaligned branch targets into a sticky ERR.
module instr_fetch #(
   parameter int unsigned         PC_WIDTH   = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter int unsigned         PC_STEP    = 4,
   parameter logic [15:0]         NOOP_INSTR = 16'hBF00,
   parameter logic [15:0]         HALT_INSTR = 16'hE000
) (
   input logic           clk,
   input logic           reset_n,
   instr_fetch_if.master bus
);
   typedef enum logic [1:0] {
      RUN,
      HALT,
      ERR
   } state_t;

   state_t state, state_n;

   logic [PC_WIDTH-1:0] pc, pc_n;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] if_pc, if_pc_n;
   logic [15:0]         if_instr, if_instr_n;
   logic                if_valid, if_valid_n;
   logic                halted, halted_n;
   logic                err, err_n;
   logic [15:0]         count, count_n;
   logic                misalign;

`ifdef FETCH_ALIGN_CHECK_EN
   assign misalign = |bus.branch_target[1:0];
`else
   assign misalign = 1'b0;
`endif

   assign pc_inc = pc + PC_WIDTH'(PC_STEP);

   assign bus.imem_addr   = pc;
   assign bus.if_instr    = if_instr;
   assign bus.if_pc       = if_pc;
   assign bus.if_valid    = if_valid;
   assign bus.halted      = halted;
   assign bus.fetch_count = count;
   assign bus.fetch_err   = err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RUN;
         pc       <= RESET_PC;
         if_pc    <= '0;
         if_instr <= NOOP_INSTR;
         if_valid <= 1'b0;
         halted   <= 1'b0;
         err      <= 1'b0;
         count    <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         if_pc    <= if_pc_n;
         if_instr <= if_instr_n;
         if_valid <= if_valid_n;
         halted   <= halted_n;
         err      <= err_n;
         count    <= count_n;
      end
   end

   // Priority: redirect > flush > stall > halt-detect > normal fetch.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      if_pc_n    = if_pc;
      if_instr_n = if_instr;
      if_valid_n = if_valid;
      halted_n   = halted;
      err_n      = err;
      count_n    = count;
      if (state != ERR) begin
         if (bus.branch_taken) begin
            if_instr_n = NOOP_INSTR;
            if_valid_n = 1'b0;
            if (misalign) begin
               state_n  = ERR;
               err_n    = 1'b1;
               halted_n = 1'b1;
            end else begin
               pc_n     = bus.branch_target;
               state_n  = RUN;
               halted_n = 1'b0;
            end
         end else if (state != HALT) begin
            if (bus.flush) begin
               if_instr_n = NOOP_INSTR;
               if_valid_n = 1'b0;
               pc_n       = pc_inc;
            end else if (!bus.stall) begin
               if (bus.imem_instr == HALT_INSTR) begin
                  if_instr_n = NOOP_INSTR;
                  if_valid_n = 1'b0;
                  state_n    = HALT;
                  halted_n   = 1'b1;
               end else begin
                  if_instr_n = bus.imem_instr;
                  if_pc_n    = pc;
                  if_valid_n = 1'b1;
                  pc_n       = pc_inc;
                  if (count != 16'hFFFF) begin
                     count_n = count + 16'd1;
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of issued
// instructions plus directed stall/flush/branch/halt/reset scenarios.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] halt_addr;
   int          n_checks;
   int          n_fail;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } exp_t;

   exp_t exp_q[$];
   exp_t want;

   instr_fetch_if #(.PC_WIDTH(16)) bus();

   instr_fetch dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] imem_word(
      input logic [15:0] a,
      input logic [15:0] h
   );
      if (a == h) return 16'hE000;
      if (a == 16'h0000) return 16'h43DF;
      if (a == 16'h0004) return 16'h6A09;
      return {4'h2, a[13:2]};
   endfunction

   always_comb bus.imem_instr = imem_word(bus.imem_addr, halt_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] a);
      exp_t e;
      e.instr = imem_word(a, halt_addr);
      e.pc    = a;
      exp_q.push_back(e);
   endtask

   task automatic branch(input logic [15:0] t);
      bus.branch_taken  = 1'b1;
      bus.branch_target = t;
      step();
      bus.branch_taken  = 1'b0;
   endtask

   task automatic test_reset();
      reset_n           = 1'b0;
      halt_addr         = 16'hFFFF;
      bus.stall         = 1'b0;
      bus.flush         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 16'h0000;
      step();
      step();
      n_checks++;
      if (bus.imem_addr !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_addr got %h want 0000", bus.imem_addr);
      end
      n_checks++;
      if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b0, 16'hBF00, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset_ifid got %b %h %h want 0 bf00 0000",
                  bus.if_valid, bus.if_instr, bus.if_pc);
      end
      n_checks++;
      if ({bus.halted, bus.fetch_err} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_flags got %b%b want 00", bus.halted, bus.fetch_err);
      end
      n_checks++;
      if (bus.fetch_count !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_count got %h want 0000", bus.fetch_count);
      end
   endtask

   task automatic test_fetch();
      logic [15:0] nxt[2];
      nxt[0] = 16'h0004;
      nxt[1] = 16'h0008;
      reset_n = 1'b1;
      n_checks++;
      if (bus.imem_addr !== 16'h0000) begin
         n_fail++;
         $display("FAIL fetch_first_addr got %h want 0000", bus.imem_addr);
      end
      for (int i = 0; i < 2; i++) begin
         push(bus.imem_addr);
         step();
         want = exp_q.pop_front();
         n_checks++;
         if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b1, want.instr, want.pc}) begin
            n_fail++;
            $display("FAIL fetch_sb got %b %h %h want 1 %h %h",
                     bus.if_valid, bus.if_instr, bus.if_pc, want.instr, want.pc);
         end
         n_checks++;
         if ({bus.imem_addr, bus.fetch_count} !== {nxt[i], 16'(i + 1)}) begin
            n_fail++;
            $display("FAIL fetch_addr_count got %h %h want %h %h",
                     bus.imem_addr, bus.fetch_count, nxt[i], 16'(i + 1));
         end
      end
   endtask

   task automatic test_stall();
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count}
             !== {16'h0008, 1'b1, 16'h6A09, 16'h0004, 16'd2}) begin
            n_fail++;
            $display("FAIL stall_hold got %h %b %h %h %h want 0008 1 6a09 0004 0002",
                     bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc,
                     bus.fetch_count);
         end
      end
      bus.stall = 1'b0;
      push(16'h0008);
      step();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL stall_sb got empty want entry");
      end else begin
         want = exp_q.pop_front();
         if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b1, want.instr, want.pc}) begin
            n_fail++;
            $display("FAIL stall_sb got %b %h %h want 1 %h %h",
                     bus.if_valid, bus.if_instr, bus.if_pc, want.instr, want.pc);
         end
      end
      n_checks++;
      if ({bus.imem_addr, bus.fetch_count} !== {16'h000C, 16'd3}) begin
         n_fail++;
         $display("FAIL stall_resume got %h %h want 000c 0003",
                  bus.imem_addr, bus.fetch_count);
      end
   endtask

   task automatic test_branch();
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      branch(16'h0068);
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      n_checks++;
      if ({bus.imem_addr, bus.if_valid, bus.if_instr, bus.fetch_count}
          !== {16'h0068, 1'b0, 16'hBF00, 16'd3}) begin
         n_fail++;
         $display("FAIL branch_redirect got %h %b %h %h want 0068 0 bf00 0003",
                  bus.imem_addr, bus.if_valid, bus.if_instr, bus.fetch_count);
      end
      push(16'h0068);
      step();
      want = exp_q.pop_front();
      n_checks++;
      if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count}
          !== {1'b1, want.instr, want.pc, 16'd4}) begin
         n_fail++;
         $display("FAIL branch_sb got %b %h %h %h want 1 %h %h 0004",
                  bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count,
                  want.instr, want.pc);
      end
   endtask

   task automatic test_flush();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      n_checks++;
      if ({bus.imem_addr, bus.if_valid, bus.if_instr, bus.fetch_count}
          !== {16'h0070, 1'b0, 16'hBF00, 16'd4}) begin
         n_fail++;
         $display("FAIL flush got %h %b %h %h want 0070 0 bf00 0004",
                  bus.imem_addr, bus.if_valid, bus.if_instr, bus.fetch_count);
      end
   endtask

   task automatic test_halt();
      halt_addr = 16'h0104;
      branch(16'h0100);
      push(16'h0100);
      step();
      want = exp_q.pop_front();
      n_checks++;
      if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count}
          !== {1'b1, want.instr, want.pc, 16'd5}) begin
         n_fail++;
         $display("FAIL halt_pre_sb got %b %h %h %h want 1 %h %h 0005",
                  bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count,
                  want.instr, want.pc);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({bus.halted, bus.imem_addr, bus.if_valid, bus.if_instr, bus.fetch_count}
             !== {1'b1, 16'h0104, 1'b0, 16'hBF00, 16'd5}) begin
            n_fail++;
            $display("FAIL halt_hold got %b %h %b %h %h want 1 0104 0 bf00 0005",
                     bus.halted, bus.imem_addr, bus.if_valid, bus.if_instr,
                     bus.fetch_count);
         end
         bus.stall = i[0];
         bus.flush = ~i[0];
         step();
      end
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      branch(16'h0040);
      halt_addr = 16'hFFFF;
      n_checks++;
      if ({bus.halted, bus.imem_addr} !== {1'b0, 16'h0040}) begin
         n_fail++;
         $display("FAIL halt_exit got %b %h want 0 0040", bus.halted, bus.imem_addr);
      end
      push(16'h0040);
      step();
      want = exp_q.pop_front();
      n_checks++;
      if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count}
          !== {1'b1, want.instr, want.pc, 16'd6}) begin
         n_fail++;
         $display("FAIL halt_resume_sb got %b %h %h %h want 1 %h %h 0006",
                  bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count,
                  want.instr, want.pc);
      end
   endtask

   task automatic test_wrap();
      branch(16'hFFFC);
      push(16'hFFFC);
      step();
      want = exp_q.pop_front();
      n_checks++;
      if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.imem_addr}
          !== {1'b1, want.instr, want.pc, 16'h0000}) begin
         n_fail++;
         $display("FAIL wrap got %b %h %h %h want 1 %h %h 0000",
                  bus.if_valid, bus.if_instr, bus.if_pc, bus.imem_addr,
                  want.instr, want.pc);
      end
   endtask

   task automatic test_saturate();
      int k;
      k = 0;
      while (bus.fetch_count != 16'hFFFF && k < 70000) begin
         step();
         k++;
      end
      for (int i = 0; i < 3; i++) step();
      n_checks++;
      if ({bus.fetch_count, bus.if_valid} !== {16'hFFFF, 1'b1}) begin
         n_fail++;
         $display("FAIL saturate got %h %b after %0d cycles want ffff 1",
                  bus.fetch_count, bus.if_valid, k);
      end
   endtask

   task automatic test_reset_mid();
      branch(16'h002C);
      step();
      n_checks++;
      if ({bus.imem_addr, bus.if_valid} !== {16'h0030, 1'b1}) begin
         n_fail++;
         $display("FAIL midreset_pre got %h %b want 0030 1",
                  bus.imem_addr, bus.if_valid);
      end
      #3;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc,
           bus.halted, bus.fetch_count}
          !== {16'h0000, 1'b0, 16'hBF00, 16'h0000, 1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL midreset_async got %h %b %h %h %b %h want 0000 0 bf00 0000 0 0000",
                  bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc,
                  bus.halted, bus.fetch_count);
      end
      exp_q.delete();
      step();
      reset_n = 1'b1;
      push(bus.imem_addr);
      step();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL midreset_sb got empty want entry");
      end else begin
         want = exp_q.pop_front();
         if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count}
             !== {1'b1, 16'h43DF, 16'h0000, 16'd1} || want.pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_sb got %b %h %h %h want 1 43df 0000 0001",
                     bus.if_valid, bus.if_instr, bus.if_pc, bus.fetch_count);
         end
      end
   endtask

   task automatic test_align();
`ifdef FETCH_ALIGN_CHECK_EN
      branch(16'h0022);
      n_checks++;
      if ({bus.fetch_err, bus.halted, bus.imem_addr, bus.if_valid}
          !== {1'b1, 1'b1, 16'h0004, 1'b0}) begin
         n_fail++;
         $display("FAIL align_trap got %b %b %h %b want 1 1 0004 0",
                  bus.fetch_err, bus.halted, bus.imem_addr, bus.if_valid);
      end
      branch(16'h0040);
      step();
      n_checks++;
      if ({bus.fetch_err, bus.halted, bus.imem_addr}
          !== {1'b1, 1'b1, 16'h0004}) begin
         n_fail++;
         $display("FAIL align_sticky got %b %b %h want 1 1 0004",
                  bus.fetch_err, bus.halted, bus.imem_addr);
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      n_checks++;
      if ({bus.fetch_err, bus.halted, bus.imem_addr} !== {1'b0, 1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL align_reset got %b %b %h want 0 0 0000",
                  bus.fetch_err, bus.halted, bus.imem_addr);
      end
`else
      branch(16'h0022);
      n_checks++;
      if ({bus.fetch_err, bus.halted, bus.imem_addr} !== {1'b0, 1'b0, 16'h0022}) begin
         n_fail++;
         $display("FAIL align_unchecked got %b %b %h want 0 0 0022",
                  bus.fetch_err, bus.halted, bus.imem_addr);
      end
`endif
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_fetch();
      test_stall();
      test_branch();
      test_flush();
      test_halt();
      test_wrap();
      test_saturate();
      test_reset_mid();
      test_align();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the 16-bit Thumb-subset core, directly upstream of the combinational instruction memory.
- Owns the PC and drives the instruction memory address.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stall, flush, branch redirect, end-of-program halt detection, and a fetched-instruction counter.

Parameters:
- PC_WIDTH, 16: PC and memory address width.
- RESET_PC, 16'h0000: PC value loaded on reset.
- PC_STEP, 4: byte increment per fetch. The memory indexes by address/4.
- NOOP_INSTR, 16'hBF00: bubble encoding placed in the IF/ID register when it holds no valid instruction.
- HALT_INSTR, 16'hE000: "B stop" encoding that ends fetch.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- imem_addr  output  PC_WIDTH  byte address to the instruction memory; equals pc combinationally.
- imem_instr  input  16  instruction returned by the memory in the same cycle.
- stall  input  1  hold PC and the IF/ID register (decode back-pressure).
- flush  input  1  squash the IF/ID contents.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  PC_WIDTH  redirect byte address.
- if_instr  output  16  registered instruction to decode.
- if_pc  output  PC_WIDTH  registered PC of if_instr.
- if_valid  output  1  if_instr is a real instruction.
- halted  output  1  fetch stopped on HALT_INSTR.
- fetch_count  output  16  count of valid instructions issued, saturating.
- fetch_err  output  1  misaligned redirect seen. Only present with the optional feature; tied 0 otherwise.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, if_instr=NOOP_INSTR, if_pc=0, if_valid=0.
  - halted=0, fetch_count=0, fetch_err=0, state=RUN.
- Reset asserted mid-operation discards everything. The first fetch after release is at RESET_PC.
- imem_addr=pc with zero latency. if_* update on the clock edge after the fetch, so there is one cycle of latency from imem_addr to if_instr.
- FSM states:
  - RUN: fetching.
  - HALT: pc frozen, if_valid=0.
  - ERR: only with the optional feature.
- Per-edge priority is redirect > flush > stall > halt-detect > normal.
- Redirect (branch_taken=1, any state except ERR):
  - pc<=branch_target.
  - if_instr<=NOOP_INSTR, if_valid<=0 (the wrong-path fetch is squashed).
  - state<=RUN, halted<=0.
  - stall and flush in the same cycle are ignored.
- Flush, no redirect: if_instr<=NOOP_INSTR, if_valid<=0, pc<=pc+PC_STEP. The PC advances because the currently fetched word is dropped.
- Stall, no redirect or flush: pc, if_instr, if_pc and if_valid all hold. fetch_count holds.
- Normal in RUN with imem_instr != HALT_INSTR:
  - if_instr<=imem_instr, if_pc<=pc, if_valid<=1.
  - pc<=pc+PC_STEP. Modulo 2^PC_WIDTH, so 16'hFFFC wraps to 0.
  - fetch_count increments and saturates at 16'hFFFF.
- Normal in RUN with imem_instr==HALT_INSTR:
  - The halt instruction is not issued: if_instr<=NOOP_INSTR, if_valid<=0.
  - pc holds at the HALT address.
  - state<=HALT, halted<=1 on the same edge.
- In HALT:
  - Outputs hold bubble and halted=1.
  - stall and flush have no effect.
  - Only a redirect or reset leaves HALT. A redirect covers an older in-flight branch that cancels the halt.
- halted and fetch_err are registered outputs.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with branch_target[1:0]!=0 does not load pc.
  - The IF/ID register is squashed to a bubble.
  - state<=ERR, fetch_err<=1 (sticky) and halted<=1.
  - ERR is left only by reset.
- Not defined: targets are loaded unchecked and fetch_err is constant 0.

Test Plan:
- Reset release with imem returning 16'h43DF at addr 0 and 16'h6A09 at addr 4 -> imem_addr 0,4,8 on successive cycles; if_instr=43DF with if_pc=0 and if_valid=1 one cycle later; fetch_count=1 then 2.
- stall held for 3 cycles at pc=8 -> imem_addr stays 8, if_* unchanged, fetch_count unchanged; fetch resumes at 12 after stall drops.
- branch_taken=1, branch_target=16'h0068, with stall=1 and flush=1 in the same cycle -> next imem_addr=0x68, if_valid=0, if_instr=BF00.
- imem_instr=E000 at pc=0x104 -> halted=1, imem_addr stays 0x104, if_valid=0 indefinitely; a later branch_taken to 0x40 -> halted=0 and fetch resumes at 0x40.
- reset_n pulsed low mid-stream at pc=0x30 -> all outputs return to reset values immediately, without waiting for a clock edge.
- With FETCH_ALIGN_CHECK_EN: branch_target=16'h0022 -> fetch_err=1, halted=1, pc unchanged; a following aligned redirect is ignored until reset.
